fp_mul_arbiter: RTL and testbench
=================================

# fp_mul_arbiter

Shares one pipelined `fp_multiplier` between `NUM_REQ` independent requesters. Each cycle a round-robin grant picks one valid request and issues it to the multiplier's `start`/`ready_out` handshake. A tag FIFO records the requester ID of every in-flight operation. Returning `result`/`flags` are steered to the matching requester's response port in issue order. The block sits between the multiplier and the compute clients.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DEPTH`, default 8: maximum in-flight operations (tag FIFO depth), power of two, ≥ 5.
- `clk` in 1: clock.
- `rst_n` in 1: reset. Synchronous, active-low; the multiplier shares this net.
- `req_valid` in NUM_REQ: request valid, one bit per requester.
- `req_ready` out NUM_REQ: request accepted.
- `req_op_a` in 32·NUM_REQ: operand A; requester i uses bits [32i+31:32i].
- `req_op_b` in 32·NUM_REQ: operand B, same slicing as `req_op_a`.
- `req_mode_fp` in NUM_REQ: 0 = half, 1 = single.
- `mul_op_a`, `mul_op_b` out 32: operands to the multiplier.
- `mul_mode_fp` out 1: mode to the multiplier.
- `mul_start` out 1: issue valid, driven to the multiplier's `start`.
- `mul_ready` in 1: the multiplier's `ready_out`.
- `mul_valid` in 1: the multiplier's `valid_out`.
- `mul_result` in 32: multiplier result.
- `mul_flags` in 5: multiplier flags.
- `mul_ready_in` out 1: drives the multiplier's `ready_in`.
- `rsp_valid` out NUM_REQ: response valid, one-hot.
- `rsp_ready` in NUM_REQ: per-requester response ready.
- `rsp_result` out 32: response result, shared by all requesters.
- `rsp_flags` out 5: response flags, shared by all requesters.
- `inflight` out clog2(DEPTH)+1: current FIFO occupancy.
- `err` out 1: sticky protocol error.

## Operation
- **Grant**
  - Round-robin over `req_valid`, starting at `(last_grant+1) mod NUM_REQ`.
  - The grant is purely combinational from `req_valid` and `last_grant`.
- **Issue**
  - `mul_start = |req_valid && !fifo_full`.
  - `mul_*` operands and mode are muxed from the granted requester.
  - Issue fires when `mul_start && mul_ready`.
  - `req_ready[i] = grant[i] && mul_ready && !fifo_full`; all other `req_ready` bits are 0.
- **Issue side effects**
  - Push the granted ID into the tag FIFO.
  - Set `last_grant` to the granted ID.
- **Return**
  - Let `head` be the tag at the FIFO head.
  - `rsp_valid = mul_valid && !fifo_empty ? onehot(head) : 0`.
  - `rsp_result`/`rsp_flags` pass `mul_result`/`mul_flags` through combinationally.
  - `mul_ready_in = !fifo_empty && rsp_ready[head]`.
  - The response fires on `mul_valid && mul_ready_in`, which pops the FIFO.
- **Simultaneous push and pop:** both happen and `inflight` is unchanged.
- **Full FIFO:** issue is blocked even when a pop occurs in the same cycle. This is a single-cycle throughput loss, accepted by design.
- **Unmatched result:** `mul_valid` with an empty FIFO sets `err` and leaves the result unconsumed (`mul_ready_in = 0`).
- **`err`:** cleared only by reset.
- **Ordering:** the multiplier is in-order, so FIFO order matches result order. No reordering logic exists.
- **Back-pressure:** a requester holding `rsp_ready` low stalls all returns (head-of-line blocking); other requesters may still issue until the FIFO is full.

## Timing
- **Reset** (`rst_n` low at a `clk` edge):
  - FIFO cleared, `inflight` = 0, `err` = 0.
  - `last_grant` = NUM_REQ−1, so requester 0 wins first.
  - All registered state is cleared; combinational outputs follow from it: `req_ready` = 0, `rsp_valid` = 0, `mul_start` = 0 when no request is valid.
- **Reset mid-operation:** all in-flight tags are discarded. The multiplier is reset on the same edge, so no orphaned results return.
- **Issue path:** 0-cycle combinational pass-through; one operation per cycle maximum.
- **Latency:** response latency equals the multiplier's, 4 cycles minimum from an accepted `mul_start` to `mul_valid`, plus any `rsp_ready` stall.
- **Occupancy:** `inflight` updates on the edge after push/pop.
- **Fairness:** with all requesters continuously valid, grants cycle 0,1,2,3,0,…, one per issue.

## Structure
- **Shared package `fp_mul_pkg`:**
  - `FP_W=32`, `FLAGS_W=5`.
  - `MODE_HALF=1'b0`, `MODE_SINGLE=1'b1`.
  - Function `rr_next(valid, last)`.
- **Sub-module `fp_mul_tag_fifo`:** synchronous FIFO of width clog2(NUM_REQ), depth `DEPTH`, with `full`/`empty`/`count` outputs.
- **Top level:** grant, mux and steering logic in `fp_mul_arbiter`.

## Test plan
- **Single request:** reset, then requester 0 issues single `0x3F800000 × 0x40000000`. Required: `req_ready[0]` in the same cycle; `rsp_valid = 4'b0001`, `rsp_result = 0x40000000`, `rsp_flags = 0` after ≥ 4 cycles; `inflight` returns to 0.
- **Half mode:** requester 2 issues `0x3C00 × 0x4000` with mode 0. Required: `rsp_valid = 4'b0100`, `rsp_result = 0x40000000`.
- **Round-robin fairness:** all 4 valid for 8 cycles with `rsp_ready` all 1. Required: grant order 0,1,2,3,0,1,2,3, and responses return in the same order.
- **FIFO full:** `DEPTH = 8`, `rsp_ready` = 0, continuous requests. Required: 8 issues accepted, then `req_ready` = 0 and `inflight = 8`; raising `rsp_ready` drains in order, and issue resumes once `inflight < 8`.
- **Reset mid-operation:** 3 operations in flight, then `rst_n` low for 1 cycle. Required: `inflight = 0`, `rsp_valid = 0`, `err = 0`, and the first post-reset grant goes to requester 0.
- **Protocol error:** force `mul_valid = 1` with an empty FIFO. Required: `err = 1` next cycle, remaining 1 until reset, and `mul_ready_in = 0`.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the floating-point multiplier arbiter.
//   FP_W / FLAGS_W   : multiplier data and flag widths
//   MODE_HALF/SINGLE : encodings of the mode bit sent to the multiplier
//   mul_req_t        : one requester's operands and mode
//   rr_next()        : round-robin pick over up to MAX_REQ request bits
package fp_mul_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned FLAGS_W = 5;

    localparam logic MODE_HALF   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    // rr_next works on a fixed-width vector; narrower request sets are zero-padded.
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned RR_W    = 3;

    typedef struct packed {
        logic [FP_W-1:0] op_a;
        logic [FP_W-1:0] op_b;
        logic            mode_fp;
    } mul_req_t;

    // Returns the first set bit of valid found scanning upward from last+1
    // (wrapping), with last itself as the lowest priority. Returns last when
    // nothing is valid. Padding bits above the real requester count are zero,
    // so a mod-MAX_REQ scan matches a mod-NUM_REQ scan.
    function automatic logic [RR_W-1:0] rr_next(input logic [MAX_REQ-1:0] valid,
                                                 input logic [RR_W-1:0]    last);
        logic [RR_W-1:0] idx;
        rr_next = last;
        // Scan from the farthest candidate down so the nearest one wins.
        for (int k = MAX_REQ; k >= 1; k--) begin
            idx = last + RR_W'(k);
            if (valid[idx]) begin
                rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/fp_mul_tag_fifo.sv
// Tag FIFO holding the requester ID of every operation in flight in the
// multiplier, oldest at the head.
//   clk, rst_n   : clock, synchronous active-low reset
//   push, wdata  : enqueue a tag (ignored when full)
//   pop          : dequeue the head tag (ignored when empty)
//   rdata        : tag at the head (valid when !empty)
//   full, empty  : occupancy flags
//   count        : number of stored tags, 0..DEPTH
module fp_mul_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one in-order pipelined fp multiplier between NUM_REQ requesters.
// A round-robin grant issues one request per cycle; a tag FIFO remembers who
// issued each operation so returning results are steered back in order.
//   clk, rst_n            : clock, synchronous active-low reset (shared with multiplier)
//   req_valid/req_ready   : per-requester issue handshake
//   req_op_a/b, req_mode_fp : per-requester operands (32 bits each) and mode
//   mul_op_a/b, mul_mode_fp, mul_start, mul_ready : issue side of the multiplier
//   mul_valid, mul_result, mul_flags, mul_ready_in : return side of the multiplier
//   rsp_valid/rsp_ready   : per-requester response handshake (rsp_valid one-hot)
//   rsp_result, rsp_flags : shared response data
//   inflight              : tag FIFO occupancy
//   err                   : sticky, set by a result arriving with nothing in flight
module fp_mul_arbiter
    import fp_mul_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [FP_W*NUM_REQ-1:0] req_op_a,
    input  logic [FP_W*NUM_REQ-1:0] req_op_b,
    input  logic [NUM_REQ-1:0]      req_mode_fp,
    output logic [FP_W-1:0]         mul_op_a,
    output logic [FP_W-1:0]         mul_op_b,
    output logic                    mul_mode_fp,
    output logic                    mul_start,
    input  logic                    mul_ready,
    input  logic                    mul_valid,
    input  logic [FP_W-1:0]         mul_result,
    input  logic [FLAGS_W-1:0]      mul_flags,
    output logic                    mul_ready_in,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [FP_W-1:0]         rsp_result,
    output logic [FLAGS_W-1:0]      rsp_flags,
    output logic [$clog2(DEPTH):0]  inflight,
    output logic                    err
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [RR_W-1:0]    last_grant_q, last_grant_d;
    logic               err_q, err_d;
    logic [RR_W-1:0]    grant_idx;
    logic               any_valid;
    logic               issue;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ID_W-1:0]    head_id;
    logic               head_ready;
    mul_req_t           grant_req;

    // ---------------------------------------------------------------- grant
    assign any_valid = |req_valid;
    assign grant_idx = rr_next(MAX_REQ'(req_valid), last_grant_q);

    always_comb begin
        grant_req = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == RR_W'(i)) begin
                grant_req.op_a    = req_op_a[FP_W*i +: FP_W];
                grant_req.op_b    = req_op_b[FP_W*i +: FP_W];
                grant_req.mode_fp = req_mode_fp[i];
                // grant_idx points at last_grant when nothing is valid.
                req_ready[i]      = any_valid && mul_ready && !fifo_full;
            end
        end
    end

    // ---------------------------------------------------------------- issue
    // A full FIFO blocks issue even if a pop frees a slot this cycle.
    assign mul_start   = any_valid && !fifo_full;
    assign mul_op_a    = grant_req.op_a;
    assign mul_op_b    = grant_req.op_b;
    assign mul_mode_fp = grant_req.mode_fp;
    assign issue       = mul_start && mul_ready;

    always_comb begin
        last_grant_d = last_grant_q;
        if (issue) begin
            last_grant_d = grant_idx;
        end
    end

    // --------------------------------------------------------------- return
    always_comb begin
        rsp_valid  = '0;
        head_ready = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (head_id == ID_W'(i)) begin
                rsp_valid[i] = mul_valid && !fifo_empty;
                head_ready   = rsp_ready[i];
            end
        end
    end

    // The head requester's ready gates every return (head-of-line blocking).
    assign mul_ready_in = !fifo_empty && head_ready;
    assign pop          = mul_valid && mul_ready_in;
    assign rsp_result   = mul_result;
    assign rsp_flags    = mul_flags;

    // A result with no tag to match it is a multiplier protocol violation.
    always_comb begin
        err_d = err_q;
        if (mul_valid && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    assign err = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= RR_W'(NUM_REQ - 1);
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    fp_mul_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (issue),
        .wdata (ID_W'(grant_idx)),
        .pop   (pop),
        .rdata (head_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (inflight)
    );

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter. A behavioural multiplier stub (fixed 4-cycle
// latency, in-order queue, toy float product) sits on the multiplier side.
// A queue-based reference model predicts grants, responses, occupancy and err
// every cycle; directed vectors and sequences cover the corner cases.
module tb_fp_mul_arbiter;

    localparam int NR = 4;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [32*NR-1:0]   req_op_a;
    logic [32*NR-1:0]   req_op_b;
    logic [NR-1:0]      req_mode_fp;
    logic [31:0]        mul_op_a;
    logic [31:0]        mul_op_b;
    logic               mul_mode_fp;
    logic               mul_start;
    logic               mul_ready;
    logic               mul_valid;
    logic [31:0]        mul_result;
    logic [4:0]         mul_flags;
    logic               mul_ready_in;
    logic [NR-1:0]      rsp_valid;
    logic [NR-1:0]      rsp_ready;
    logic [31:0]        rsp_result;
    logic [4:0]         rsp_flags;
    logic [3:0]         inflight;
    logic               err;

    always #5 clk = ~clk;

    fp_mul_arbiter #(
        .NUM_REQ (NR),
        .DEPTH   (DP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op_a     (req_op_a),
        .req_op_b     (req_op_b),
        .req_mode_fp  (req_mode_fp),
        .mul_op_a     (mul_op_a),
        .mul_op_b     (mul_op_b),
        .mul_mode_fp  (mul_mode_fp),
        .mul_start    (mul_start),
        .mul_ready    (mul_ready),
        .mul_valid    (mul_valid),
        .mul_result   (mul_result),
        .mul_flags    (mul_flags),
        .mul_ready_in (mul_ready_in),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .inflight     (inflight),
        .err          (err)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
        int          due;
    } mop_t;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [4:0]  fl;
        logic [3:0]  rv;
    } ent_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        mode;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    mop_t mq[$];        // multiplier stub pipeline
    ent_t mexp[$];      // model: expected in-flight operations, oldest first
    ent_t rsp_log[$];   // fired responses (actual data, model id)
    int   grant_log[$]; // model grants, in issue order
    int   m_last;
    bit   m_err;
    bit   mul_rdy_en;
    bit   force_valid;
    logic [3:0] last_rr;
    logic       last_ri;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Toy float product: exact when at least one fraction is zero, otherwise the
    // fraction is scrambled and the inexact flag (bit 0) is raised. Half-mode
    // inputs live in the low 16 bits; the result is always single format.
    function automatic logic [36:0] toy_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic mode);
        logic        s;
        int          ea, eb, e;
        logic [22:0] fa, fb, f;
        logic [4:0]  fl;
        if (mode) begin
            s  = a[31] ^ b[31];
            ea = int'(a[30:23]);
            eb = int'(b[30:23]);
            fa = a[22:0];
            fb = b[22:0];
        end else begin
            s  = a[15] ^ b[15];
            ea = int'(a[14:10]) + 112;
            eb = int'(b[14:10]) + 112;
            fa = {a[9:0], 13'b0};
            fb = {b[9:0], 13'b0};
        end
        fl = 5'b0;
        if (fa == 23'b0) begin
            f = fb;
        end else if (fb == 23'b0) begin
            f = fa;
        end else begin
            f  = fa ^ fb;
            fl = 5'b00001;
        end
        e = (ea + eb - 127) & 255;
        return {fl, s, e[7:0], f};
    endfunction

    task automatic drive_mul();
        mul_ready = mul_rdy_en;
        if (force_valid) begin
            mul_valid  = 1'b1;
            mul_result = 32'hDEAD_BEEF;
            mul_flags  = 5'h1F;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            mul_valid  = 1'b1;
            mul_result = mq[0].res;
            mul_flags  = mq[0].fl;
        end else begin
            mul_valid  = 1'b0;
            mul_result = 32'h0;
            mul_flags  = 5'h0;
        end
    endtask

    // One clock cycle: settle, compare against the model, then advance both
    // the model and the stub across the edge.
    task automatic step();
        int          g;
        int          idx;
        bit          any, full, empty;
        logic [3:0]  exp_rr, exp_rv;
        logic        exp_ri;
        logic [36:0] r;
        ent_t        e;
        drive_mul();
        #1;
        any   = |req_valid;
        full  = (mexp.size() == DP);
        empty = (mexp.size() == 0);
        g = -1;
        for (int k = 1; k <= NR; k++) begin
            idx = (m_last + k) % NR;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        last_rr = req_ready;
        last_ri = mul_ready_in;
        if (rst_n) begin
            chk("mul_start", 64'(mul_start), 64'(any && !full));
            exp_rr = (g >= 0 && !full && mul_ready) ? 4'(1 << g) : 4'b0;
            chk("req_ready", 64'(req_ready), 64'(exp_rr));
            if (g >= 0 && mul_start) begin
                chk("mul_op_a", 64'(mul_op_a), 64'(req_op_a[32*g +: 32]));
                chk("mul_op_b", 64'(mul_op_b), 64'(req_op_b[32*g +: 32]));
                chk("mul_mode", 64'(mul_mode_fp), 64'(req_mode_fp[g]));
            end
            exp_rv = 4'b0;
            exp_ri = 1'b0;
            if (!empty) begin
                exp_ri = rsp_ready[mexp[0].id];
                if (mul_valid) begin
                    exp_rv = 4'(1 << mexp[0].id);
                    chk("rsp_result", 64'(rsp_result), 64'(mexp[0].res));
                    chk("rsp_flags", 64'(rsp_flags), 64'(mexp[0].fl));
                end
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            chk("mul_ready_in", 64'(mul_ready_in), 64'(exp_ri));
            chk("inflight", 64'(inflight), 64'(mexp.size()));
            chk("err", 64'(err), 64'(m_err));
        end
        if (!rst_n) begin
            mexp.delete();
            mq.delete();
            m_last = NR - 1;
            m_err  = 1'b0;
        end else begin
            if (mul_start && mul_ready) begin
                r = toy_mul(mul_op_a, mul_op_b, mul_mode_fp);
                mq.push_back('{res: r[31:0], fl: r[36:32], due: cyc + 4});
            end
            if (mul_valid && mul_ready_in && !force_valid && mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (mul_valid && empty) m_err = 1'b1;
            if (mul_valid && !empty && rsp_ready[mexp[0].id]) begin
                rsp_log.push_back('{id: mexp[0].id, res: rsp_result, fl: rsp_flags,
                                    rv: rsp_valid});
                void'(mexp.pop_front());
            end
            if (g >= 0 && !full && mul_ready) begin
                r = toy_mul(req_op_a[32*g +: 32], req_op_b[32*g +: 32], req_mode_fp[g]);
                e = '{id: g, res: r[31:0], fl: r[36:32], rv: 4'b0};
                mexp.push_back(e);
                m_last = g;
                grant_log.push_back(g);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            req_op_a[32*i +: 32] = $urandom;
            req_op_b[32*i +: 32] = $urandom;
        end
        req_mode_fp = 4'($urandom);
    endtask

    vec_t vecs[6];

    initial begin
        int n0, r0, lat, n;
        vecs[0] = '{0, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h4000_0000, 5'h0};
        vecs[1] = '{2, 32'h0000_3C00, 32'h0000_4000, 1'b0, 32'h4000_0000, 5'h0};
        vecs[2] = '{1, 32'h4000_0000, 32'h4000_0000, 1'b1, 32'h4080_0000, 5'h0};
        vecs[3] = '{3, 32'hBF80_0000, 32'h4000_0000, 1'b1, 32'hC000_0000, 5'h0};
        vecs[4] = '{1, 32'h0000_4000, 32'h0000_4000, 1'b0, 32'h4080_0000, 5'h0};
        vecs[5] = '{3, 32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3FC0_0000, 5'h0};

        rst_n       = 1'b0;
        req_valid   = '0;
        req_op_a    = '0;
        req_op_b    = '0;
        req_mode_fp = '0;
        rsp_ready   = '1;
        mul_rdy_en  = 1'b1;
        force_valid = 1'b0;
        m_last      = NR - 1;
        m_err       = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("reset_inflight", 64'(inflight), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_mul_start", 64'(mul_start), 64'd0);

        // Directed single operations.
        foreach (vecs[v]) begin
            req_op_a = '0;
            req_op_b = '0;
            req_mode_fp = '0;
            req_valid = '0;
            req_op_a[32*vecs[v].id +: 32] = vecs[v].a;
            req_op_b[32*vecs[v].id +: 32] = vecs[v].b;
            req_mode_fp[vecs[v].id] = vecs[v].mode;
            req_valid[vecs[v].id] = 1'b1;
            r0 = rsp_log.size();
            step();
            chk("vec_req_ready", 64'(last_rr), 64'(1 << vecs[v].id));
            req_valid = '0;
            lat = 0;
            while (rsp_log.size() == r0 && lat < 20) begin
                step();
                lat++;
            end
            chk("vec_rsp_seen", 64'(rsp_log.size() > r0), 64'd1);
            if (rsp_log.size() > r0) begin
                chk("vec_rsp_valid", 64'(rsp_log[$].rv), 64'(1 << vecs[v].id));
                chk("vec_result", 64'(rsp_log[$].res), 64'(vecs[v].res));
                chk("vec_flags", 64'(rsp_log[$].fl), 64'(vecs[v].fl));
                chk("vec_latency_ge4", 64'(lat >= 4), 64'd1);
            end
            step();
            chk("vec_inflight_idle", 64'(inflight), 64'd0);
        end

        // Reset with three operations in flight.
        req_valid = 4'b0010;
        rand_ops();
        repeat (3) step();
        req_valid = '0;
        chk("mid_inflight3", 64'(inflight), 64'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_inflight0", 64'(inflight), 64'd0);
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_err", 64'(err), 64'd0);
        repeat (6) step();
        chk("mid_no_orphans", 64'(rsp_valid), 64'd0);

        // Fairness with everyone valid; first grant after reset must be 0.
        grant_log.delete();
        rsp_log.delete();
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        repeat (16) step();
        chk("fair_count", 64'(grant_log.size()), 64'd8);
        chk("fair_rsp_count", 64'(rsp_log.size()), 64'd8);
        n = (grant_log.size() < 8) ? grant_log.size() : 8;
        for (int i = 0; i < n; i++) chk("fair_grant", 64'(grant_log[i]), 64'(i % 4));
        n = (rsp_log.size() < 8) ? rsp_log.size() : 8;
        for (int i = 0; i < n; i++) chk("fair_rsp_order", 64'(rsp_log[i].id), 64'(i % 4));

        // Fill the FIFO with returns blocked, then drain and resume.
        grant_log.delete();
        rsp_log.delete();
        rsp_ready = '0;
        req_valid = 4'hF;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            step();
        end
        chk("full_issues", 64'(grant_log.size()), 64'd8);
        chk("full_inflight", 64'(inflight), 64'd8);
        chk("full_req_ready", 64'(last_rr), 64'd0);
        rsp_ready = '1;
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            step();
        end
        chk("full_resumed", 64'(grant_log.size() > 8), 64'd1);
        req_valid = '0;
        repeat (30) step();
        chk("full_drain_count", 64'(rsp_log.size()), 64'(grant_log.size()));
        n = (rsp_log.size() < grant_log.size()) ? rsp_log.size() : grant_log.size();
        for (int i = 0; i < n; i++) chk("full_drain_order", 64'(rsp_log[i].id), 64'(grant_log[i]));

        // Randomized traffic with back-pressure on both sides.
        n0 = grant_log.size();
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            req_valid = 4'($urandom);
            for (int j = 0; j < NR; j++) rsp_ready[j] = ($urandom_range(0, 3) != 0);
            mul_rdy_en = ($urandom_range(0, 4) != 0);
            step();
        end
        req_valid  = '0;
        rsp_ready  = '1;
        mul_rdy_en = 1'b1;
        repeat (30) step();
        chk("rand_issued_some", 64'(grant_log.size() > n0 + 50), 64'd1);
        chk("rand_drained", 64'(inflight), 64'd0);

        // Result with nothing in flight.
        force_valid = 1'b1;
        step();
        force_valid = 1'b0;
        chk("pe_ready_in", 64'(last_ri), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("pe_err_sticky", 64'(err), 64'd1);
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("pe_err_cleared", 64'(err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
